vcap_line_writer: RTL

VCAP_LINE_WRITER -- requirements
Module: vcap_line_writer

---
 rtl/vcap_line_writer_if.sv | 35 +++
 rtl/vcap_line_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vcap_line_writer_if.sv
// -----------------------------------------------------------------------------
// vcap_line_writer_if
// Groups the two handshakes of the video-capture line writer:
//   - capture FIFO side: i_fifo_active (line waiting), i_fifo_line (its line
//     number), i_fifo_data (show-ahead head word {R,G,B}), o_fifo_next (pop),
//     o_fifo_reset (one-cycle release of i_fifo_active)
//   - RAM burst-write side: o_ram_req/o_ram_addr/o_ram_len (burst command),
//     i_ram_ack (command accepted), i_ram_data_next (word consumed this
//     cycle), o_ram_data (write word)
// Signal names carry the writer's point of view (i_ = into the writer).
// modport master: the line writer.  modport slave: the FIFO/RAM environment.
// -----------------------------------------------------------------------------
interface vcap_line_writer_if;
    logic        i_fifo_active;
    logic [8:0]  i_fifo_line;
    logic [11:0] i_fifo_data;
    logic        o_fifo_next;
    logic        o_fifo_reset;
    logic        o_ram_req;
    logic [18:0] o_ram_addr;
    logic [3:0]  o_ram_len;
    logic        i_ram_ack;
    logic        i_ram_data_next;
    logic [15:0] o_ram_data;

    modport master (
        input  i_fifo_active, i_fifo_line, i_fifo_data, i_ram_ack, i_ram_data_next,
        output o_fifo_next, o_fifo_reset, o_ram_req, o_ram_addr, o_ram_len, o_ram_data
    );

    modport slave (
        output i_fifo_active, i_fifo_line, i_fifo_data, i_ram_ack, i_ram_data_next,
        input  o_fifo_next, o_fifo_reset, o_ram_req, o_ram_addr, o_ram_len, o_ram_data
    );
endinterface

// File: rtl/vcap_line_writer.sv
// -----------------------------------------------------------------------------
// vcap_line_writer
// Moves one captured video line at a time from a show-ahead capture FIFO into
// frame-buffer RAM as a sequence of burst writes, or drains and discards the
// line when capture is disabled.
//
// Ports
//   i_ram_clk        RAM-domain clock, all state on its rising edge
//   i_reset          synchronous active-high reset
//   i_enable         1: store lines to RAM, 0: drain and discard (latched per line)
//   i_buf_sel        frame buffer select (latched per line)
//   i_x_size         capture width  - 1
//   i_y_size         capture height - 1
//   bus              FIFO + RAM handshakes (vcap_line_writer_if.master)
//   o_busy           state machine not idle
//   o_line_done      one-cycle pulse per completed line
//   o_frame_done     one-cycle pulse when the completed line is the last one
//   o_lines_dropped  saturating count of drained lines
//
// RAM word address = {buf, line[8:0], col[8:0]}; a line holds at most 512 words.
// -----------------------------------------------------------------------------
module vcap_line_writer #(
    parameter int SCR_SIZE_BIT = 10,
    parameter int BURST_LEN    = 8
) (
    input  logic                    i_ram_clk,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic                    i_buf_sel,
    input  logic [SCR_SIZE_BIT:0]   i_x_size,
    input  logic [SCR_SIZE_BIT:0]   i_y_size,
    vcap_line_writer_if.master      bus,
    output logic                    o_busy,
    output logic                    o_line_done,
    output logic                    o_frame_done,
    output logic [7:0]              o_lines_dropped
);

    localparam int XW = SCR_SIZE_BIT + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ,
        DATA,
        DRAIN,
        DONE,
        WAIT
    } state_t;

    state_t      state_q;
    logic [8:0]  line_q;
    logic        buf_q;
    logic [9:0]  col_q;
    logic [9:0]  remain_q;
    logic [3:0]  beats_q;
    logic        busy_q;
    logic        ram_req_q;
    logic [18:0] ram_addr_q;
    logic [3:0]  ram_len_q;
    logic        line_done_q;
    logic        frame_done_q;
    logic        fifo_reset_q;
    logic [7:0]  dropped_q;

    logic [9:0]  remain_init;
    logic [8:0]  y_last;
    logic [8:0]  col_lo_next;

    // Words in the line: width clamped to 512 so col never wraps.
    generate
        if (XW > 9) begin : g_wide
            logic unused_y_hi;
            assign remain_init = (i_x_size >= XW'(511)) ? 10'd512 : (10'(i_x_size) + 10'd1);
            // Only the low nine bits of the height match a line number.
            assign y_last      = i_y_size[8:0];
            assign unused_y_hi = ^i_y_size[XW-1:9];
        end else begin : g_narrow
            assign remain_init = 10'(i_x_size) + 10'd1;
            assign y_last      = 9'(i_y_size);
        end
    endgenerate

    assign col_lo_next = col_q[8:0] + 9'd1;

    // Length of the next burst given the words still owed for this line.
    function automatic logic [3:0] burst_of(input logic [9:0] words);
        return (words > 10'(BURST_LEN)) ? 4'(BURST_LEN) : words[3:0];
    endfunction

    always_ff @(posedge i_ram_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            line_q       <= 9'd0;
            buf_q        <= 1'b0;
            col_q        <= 10'd0;
            remain_q     <= 10'd0;
            beats_q      <= 4'd0;
            busy_q       <= 1'b0;
            ram_req_q    <= 1'b0;
            ram_addr_q   <= 19'd0;
            ram_len_q    <= 4'd0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            fifo_reset_q <= 1'b0;
            dropped_q    <= 8'd0;
        end else begin
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            fifo_reset_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.i_fifo_active) begin
                        state_q <= SETUP;
                        busy_q  <= 1'b1;
                    end
                end

                SETUP: begin
                    line_q   <= bus.i_fifo_line;
                    buf_q    <= i_buf_sel;
                    col_q    <= 10'd0;
                    remain_q <= remain_init;
                    if (i_enable) begin
                        // First burst command is registered on the way into REQ.
                        state_q    <= REQ;
                        ram_req_q  <= 1'b1;
                        ram_addr_q <= {i_buf_sel, bus.i_fifo_line, 9'd0};
                        ram_len_q  <= burst_of(remain_init);
                    end else begin
                        state_q <= DRAIN;
                    end
                end

                REQ: begin
                    if (bus.i_ram_ack) begin
                        beats_q    <= ram_len_q;
                        ram_req_q  <= 1'b0;
                        ram_addr_q <= 19'd0;
                        ram_len_q  <= 4'd0;
                        state_q    <= DATA;
                    end
                end

                DATA: begin
                    if (bus.i_ram_data_next) begin
                        beats_q  <= beats_q - 4'd1;
                        remain_q <= remain_q - 10'd1;
                        col_q    <= col_q + 10'd1;
                        if (beats_q == 4'd1) begin
                            if (remain_q == 10'd1) begin
                                state_q      <= DONE;
                                line_done_q  <= 1'b1;
                                fifo_reset_q <= 1'b1;
                                frame_done_q <= (line_q == y_last);
                            end else begin
                                state_q    <= REQ;
                                ram_req_q  <= 1'b1;
                                ram_addr_q <= {buf_q, line_q, col_lo_next};
                                ram_len_q  <= burst_of(remain_q - 10'd1);
                            end
                        end
                    end
                end

                DRAIN: begin
                    remain_q <= remain_q - 10'd1;
                    if (remain_q == 10'd1) begin
                        state_q      <= DONE;
                        line_done_q  <= 1'b1;
                        fifo_reset_q <= 1'b1;
                        frame_done_q <= (line_q == y_last);
                        if (dropped_q != 8'hFF) begin
                            dropped_q <= dropped_q + 8'd1;
                        end
                    end
                end

                DONE: begin
                    state_q <= WAIT;
                end

                WAIT: begin
                    // The FIFO needs a cycle to drop its level flag after the
                    // release pulse; waiting for it avoids re-running the line.
                    if (!bus.i_fifo_active) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Pops and write data must follow the RAM's consume strobe in the same
    // cycle, so they are decoded from state; reset masks them immediately.
    assign bus.o_fifo_next = !i_reset &&
                             (((state_q == DATA) && bus.i_ram_data_next) || (state_q == DRAIN));
    assign bus.o_ram_data  = (!i_reset && (state_q == DATA)) ? {4'b0000, bus.i_fifo_data} : 16'h0000;

    assign bus.o_fifo_reset = fifo_reset_q;
    assign bus.o_ram_req    = ram_req_q;
    assign bus.o_ram_addr   = ram_addr_q;
    assign bus.o_ram_len    = ram_len_q;
    assign o_busy           = busy_q;
    assign o_line_done      = line_done_q;
    assign o_frame_done     = frame_done_q;
    assign o_lines_dropped  = dropped_q;

endmodule
